// File: rtl/apb_timer_tick_prescaler.sv
// Tick prescaler ahead of an APB timer counter half.
// It selects clk_i cycles or rising edges of ref_i as the event source. Every
// (cfg_presc_val_i + 1) events it emits one registered tick pulse.
module apb_timer_tick_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_en_i,
    input  logic               cfg_sel_ref_i,
    input  logic               cfg_presc_en_i,
    input  logic [PRESC_W-1:0] cfg_presc_val_i,
    input  logic               cfg_clear_i,
    input  logic               ref_i,
    output logic               tick_o,
    output logic [PRESC_W-1:0] presc_cnt_o
);

    logic               ref_q;
    logic               ev;
    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;
    logic               tick_d;

    // ref_q tracks ref_i even during reset and while disabled.
    // A level that is already high never looks like a fresh edge.
    always_ff @(posedge clk_i) begin
        ref_q <= ref_i;
    end

    assign ev = cfg_sel_ref_i ? (ref_i & ~ref_q) : 1'b1;

    // Next count and tick, using first-match priority.
    // A compare of >= (rather than ==) lets a lowered compare value terminate at once.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cfg_clear_i) begin
            cnt_d = '0;
        end else if (!cfg_en_i) begin
            cnt_d = cnt_q;
        end else if (ev && !cfg_presc_en_i) begin
            tick_d = 1'b1;
            cnt_d  = '0;
        end else if (ev && (cnt_q >= cfg_presc_val_i)) begin
            tick_d = 1'b1;
            cnt_d  = '0;
        end else if (ev) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count and tick registers, with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_o <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_o <= tick_d;
        end
    end

    assign presc_cnt_o = cnt_q;

endmodule
